axi_lite_led_ctrl: RTL
======================

// Module: axi_lite_led_ctrl
// PURPOSE
//  AXI4-Lite slave driving the 4-bit board LEDs. Sits downstream of the PS7 M_AXI_GP0
//  interconnect, in parallel with the BRAM controller.
//  Adds static, blink and PWM LED modes, programmed through a 5-register map.
//  The PS writes and reads it with the same write_data/read_data BFM calls used for the GPIO.
// PARAMETERS
//  ADDR_WIDTH  12  byte-address width of the AXI-Lite slave port (4 KB window)
//  LED_WIDTH   4   number of LED outputs
// PORTS
//  ACLK           in   1           clock (FCLK_CLK0 domain)
//  ARESETn        in   1           asynchronous active-low reset
//  S_AXI_AWADDR   in   ADDR_WIDTH  write address
//  S_AXI_AWVALID  in   1           write address valid
//  S_AXI_AWREADY  out  1           write address ready
//  S_AXI_WDATA    in   32          write data
//  S_AXI_WSTRB    in   4           write byte strobes
//  S_AXI_WVALID   in   1           write data valid
//  S_AXI_WREADY   out  1           write data ready
//  S_AXI_BRESP    out  2           write response
//  S_AXI_BVALID   out  1           write response valid
//  S_AXI_BREADY   in   1           write response ready
//  S_AXI_ARADDR   in   ADDR_WIDTH  read address
//  S_AXI_ARVALID  in   1           read address valid
//  S_AXI_ARREADY  out  1           read address ready
//  S_AXI_RDATA    out  32          read data
//  S_AXI_RRESP    out  2           read response
//  S_AXI_RVALID   out  1           read data valid
//  S_AXI_RREADY   in   1           read data ready
//  led_o          out  LED_WIDTH   registered LED drive
// BEHAVIOUR
//  Reset: every output 0; every register 0; counter and phase 0. Applies asynchronously,
//   including mid-transaction: pending B/R responses are dropped.
//  Register map (word-aligned; addr[1:0] ignored):
//   0x00 DATA [3:0] RW
//   0x04 MODE [1:0] RW: 0 static, 1 blink, 2 PWM, 3 treated as static
//   0x08 PERIOD [31:0] RW
//   0x0C DUTY [31:0] RW
//   0x10 STATUS RO: [3:0]=led_o, [4]=phase, rest 0
//  Offsets >= 0x14 are out of range:
//   writes ignored, BRESP=SLVERR (2'b10); reads RDATA=0, RRESP=SLVERR.
//   Writes to STATUS are ignored with BRESP=OKAY.
//  Write channel:
//   AWREADY and WREADY are asserted together for exactly 1 cycle when
//    AWVALID & WVALID & !BVALID. Never accept AW without W.
//   The register updates on that edge; only byte lanes with WSTRB set are written.
//   BVALID rises the next cycle and holds until BREADY. One outstanding write.
//  Read channel:
//   ARREADY is 1 cycle when ARVALID & !RVALID. RDATA is captured on that edge;
//    RVALID holds until RREADY. One outstanding read.
//   Read and write are independent and may complete in the same cycle.
//   A same-cycle read of a register being written returns the old value.
//  LED engine (counter cnt, 32-bit):
//   static: led_o <= DATA.
//   blink: cnt counts 0..PERIOD. At cnt==PERIOD, cnt<=0 and phase toggles.
//    led_o <= phase ? DATA : 0. PERIOD=0 toggles every cycle.
//   PWM: cnt wraps 0..PERIOD as in blink. led_o <= (cnt < DUTY) ? DATA : 0.
//    DUTY > PERIOD gives always on; DUTY=0 gives always off.
//   Any accepted write to MODE or PERIOD clears cnt and phase on the same edge.
//   led_o reflects new register values 1 cycle after the write edge.
// TESTING
//  1. Reset, write 0x00 <- 0xF (MODE=0) -> led_o=4'hF 1 cycle after AWREADY; BRESP=OKAY.
//  2. DATA=0x5, PERIOD=3, MODE=1 -> led_o alternates 0 / 4'h5 every 4 cycles;
//     STATUS[4] tracks phase.
//  3. DATA=0xF, PERIOD=9, DUTY=3, MODE=2 -> led_o=4'hF for 3 of every 10 cycles;
//     DUTY=0 -> always 0; DUTY=20 -> always 4'hF.
//  4. Write 0x20 -> BRESP=2'b10, no register changes.
//     Read 0x20 -> RDATA=0, RRESP=2'b10.
//     Write DATA with WSTRB=4'b0000 -> DATA unchanged.
//  5. Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID stay high, no new AW/AR accepted;
//     concurrent read+write of DATA -> read returns old value.
//  6. Assert ARESETn low mid-blink with BVALID pending -> all outputs 0 immediately;
//     after release, DATA reads 0.

Source files
------------

// File: rtl/axi_lite_led_ctrl.sv
// AXI4-Lite slave driving the board LEDs in static, blink or PWM mode.
// Register map: DATA, MODE, PERIOD, DUTY (RW) and STATUS (RO); one outstanding read and write.

module axi_lite_led_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int LED_WIDTH  = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic [LED_WIDTH-1:0]  led_o
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] IDX_DATA   = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_MODE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_PERIOD = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_DUTY   = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(4);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_PWM    = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    logic [LED_WIDTH-1:0] data_q, data_d;
    mode_e                mode_q, mode_d;
    logic [31:0]          period_q, period_d;
    logic [31:0]          duty_q, duty_d;
    logic [31:0]          cnt_q, cnt_d;
    logic                 phase_q, phase_d;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic                 bvalid_q;
    logic [1:0]           bresp_q;
    logic                 rvalid_q;
    logic [31:0]          rdata_q;
    logic [1:0]           rresp_q;

    logic             wr_en, rd_en, clr;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             wr_ok, rd_ok;
    logic [31:0]      rd_val;
    logic             unused_addr_lsb;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    // Ready is gated by reset so every output reads 0 while ARESETn is low.
    assign wr_en  = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ARESETn;
    assign rd_en  = S_AXI_ARVALID & ~rvalid_q & ARESETn;
    assign wr_idx = S_AXI_AWADDR[ADDR_WIDTH-1:2];
    assign rd_idx = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    assign wr_ok  = (wr_idx <= IDX_STATUS);
    assign rd_ok  = (rd_idx <= IDX_STATUS);
    assign unused_addr_lsb = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        data_d   = data_q;
        mode_d   = mode_q;
        period_d = period_q;
        duty_d   = duty_q;
        clr      = 1'b0;
        if (wr_en) begin
            case (wr_idx)
                IDX_DATA:   if (S_AXI_WSTRB[0]) data_d = S_AXI_WDATA[LED_WIDTH-1:0];
                IDX_MODE: begin
                    if (S_AXI_WSTRB[0]) mode_d = mode_e'(S_AXI_WDATA[1:0]);
                    clr = 1'b1;
                end
                IDX_PERIOD: begin
                    period_d = apply_strb(period_q, S_AXI_WDATA, S_AXI_WSTRB);
                    clr      = 1'b1;
                end
                IDX_DUTY:   duty_d = apply_strb(duty_q, S_AXI_WDATA, S_AXI_WSTRB);
                default: ;
            endcase
        end
    end

    // Counter runs only in blink/PWM; phase toggles only in blink, so STATUS[4] stays 0 elsewhere.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clr) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (mode_q == MODE_BLINK || mode_q == MODE_PWM) begin
            if (cnt_q == period_q) begin
                cnt_d = '0;
                if (mode_q == MODE_BLINK) phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        case (mode_q)
            MODE_BLINK: led_d = phase_q ? data_q : '0;
            MODE_PWM:   led_d = (cnt_q < duty_q) ? data_q : '0;
            default:    led_d = data_q;
        endcase
    end

    always_comb begin
        rd_val = '0;
        case (rd_idx)
            IDX_DATA:   rd_val = 32'(data_q);
            IDX_MODE:   rd_val = {30'd0, mode_q};
            IDX_PERIOD: rd_val = period_q;
            IDX_DUTY:   rd_val = duty_q;
            IDX_STATUS: rd_val = 32'(led_q) | (32'(phase_q) << 4);
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            data_q   <= '0;
            mode_q   <= MODE_STATIC;
            period_q <= '0;
            duty_q   <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            led_q    <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            data_q   <= data_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            led_q    <= led_d;
            if (wr_en) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_ok ? rd_val : 32'd0;
                rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = wr_en;
    assign S_AXI_WREADY  = wr_en;
    assign S_AXI_ARREADY = rd_en;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign led_o         = led_q;

endmodule
